// File: rtl/thermal_plant.sv
// -----------------------------------------------------------------------------
// thermal_plant
//   Room model at the far end of the air-conditioning loop. It takes the
//   heating/cooling commands from the ac controller and produces the 5-bit
//   room temperature the controller reads back, closing the loop for
//   system-level simulation and FPGA demos.
//
//   Every TICK_DIV enabled clocks an update tick occurs:
//   - Heating raises the temperature one degree, saturating at 31.
//   - Cooling lowers it one degree, saturating at 0.
//   - When both are asserted the temperature holds and a sticky fault is raised.
//   - While idle, every AMBIENT_DIV ticks the room drifts one degree toward
//     AMBIENT.
//
// Ports
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   enable       in   1  1 = plant evolves, 0 = all state holds
//   heating      in   1  heating command
//   cooling      in   1  cooling command
//   load         in   1  synchronous preset of temperature (beats enable)
//   load_value   in   5  value written on load
//   temperature  out  5  registered room temperature
//   tick         out  1  registered one-cycle pulse per update tick
//   fault        out  1  sticky: heating and cooling together on a tick
//   at_min       out  1  temperature == 0
//   at_max       out  1  temperature == 31
//
// Handshake: none. Inputs are levels, sampled only on the tick edge;
// outputs are valid every cycle.
// -----------------------------------------------------------------------------
module thermal_plant #(
    parameter int         TICK_DIV    = 4,
    parameter int         AMBIENT_DIV = 4,
    parameter logic [4:0] AMBIENT     = 5'd18,
    parameter logic [4:0] INIT_TEMP   = 5'd18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       heating,
    input  logic       cooling,
    input  logic       load,
    input  logic [4:0] load_value,
    output logic [4:0] temperature,
    output logic       tick,
    output logic       fault,
    output logic       at_min,
    output logic       at_max
);

    // AMBIENT_DIV may be 1, which would give a zero-width counter.
    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = (AMBIENT_DIV > 1) ? $clog2(AMBIENT_DIV) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DRIFT_LAST = DW'(AMBIENT_DIV - 1);

    logic [TW-1:0] tick_cnt;
    logic [DW-1:0] drift_cnt;

    // Next values applied on a tick edge.
    logic [4:0]    temp_upd;
    logic [DW-1:0] drift_upd;
    logic          fault_upd;

    always_comb begin
        temp_upd  = temperature;
        drift_upd = '0;
        fault_upd = fault;
        if (heating && cooling) begin
            fault_upd = 1'b1;
        end else if (heating) begin
            if (temperature != 5'd31) temp_upd = temperature + 5'd1;
        end else if (cooling) begin
            if (temperature != 5'd0) temp_upd = temperature - 5'd1;
        end else if (drift_cnt != DRIFT_LAST) begin
            drift_upd = drift_cnt + DW'(1);
        end else begin
            // Drift step: move one degree toward ambient, hold when there.
            if (temperature < AMBIENT)
                temp_upd = temperature + 5'd1;
            else if (temperature > AMBIENT)
                temp_upd = temperature - 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            temperature <= INIT_TEMP;
            tick        <= 1'b0;
            fault       <= 1'b0;
            tick_cnt    <= '0;
            drift_cnt   <= '0;
        end else if (load) begin
            // Preset restarts both dividers so the next tick is a full
            // period away; fault is deliberately left alone.
            temperature <= load_value;
            tick_cnt    <= '0;
            drift_cnt   <= '0;
            tick        <= 1'b0;
        end else if (enable) begin
            if (tick_cnt == TICK_LAST) begin
                tick_cnt    <= '0;
                tick        <= 1'b1;
                temperature <= temp_upd;
                drift_cnt   <= drift_upd;
                fault       <= fault_upd;
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
                tick     <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

    assign at_min = (temperature == 5'd0);
    assign at_max = (temperature == 5'd31);

endmodule

// File: tb/tb_thermal_plant.sv
module tb_thermal_plant;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       heating;
    logic       cooling;
    logic       load;
    logic [4:0] load_value;
    logic [4:0] temperature;
    logic       tick;
    logic       fault;
    logic       at_min;
    logic       at_max;

    int checks = 0;
    int errors = 0;

    thermal_plant dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .heating     (heating),
        .cooling     (cooling),
        .load        (load),
        .load_value  (load_value),
        .temperature (temperature),
        .tick        (tick),
        .fault       (fault),
        .at_min      (at_min),
        .at_max      (at_max)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver / check tasks ----------------
    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [4:0] v);
        load       = 1'b1;
        load_value = v;
        step(1);
        load       = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        heating    = 1'b0;
        cooling    = 1'b0;
        load       = 1'b0;
        load_value = 5'd0;

        // Reset state
        step(2);
        check("reset_temp",  int'(temperature), 18);
        check("reset_tick",  int'(tick), 0);
        check("reset_fault", int'(fault), 0);
        check("reset_min",   int'(at_min), 0);
        check("reset_max",   int'(at_max), 0);

        // 1: heating from reset, first tick on the 4th edge
        rst_n   = 1'b1;
        enable  = 1'b1;
        heating = 1'b1;
        step(3);
        check("t1_pre_temp", int'(temperature), 18);
        check("t1_pre_tick", int'(tick), 0);
        step(1);
        check("t1_first_temp", int'(temperature), 19);
        check("t1_first_tick", int'(tick), 1);
        step(1);
        check("t1_tick_drop", int'(tick), 0);
        step(3);
        for (int k = 2; k <= 13; k++) begin
            check("t1_heat_temp", int'(temperature), 18 + k);
            check("t1_heat_tick", int'(tick), 1);
            if (k < 13) step(4);
        end
        check("t1_at_max", int'(at_max), 1);
        step(4);
        check("t1_sat_temp", int'(temperature), 31);
        check("t1_sat_tick", int'(tick), 1);
        check("t1_sat_max",  int'(at_max), 1);

        // 2: load while disabled, then cool to 0 and saturate
        enable = 1'b0;
        do_load(5'd2);
        check("t2_load_temp", int'(temperature), 2);
        check("t2_load_tick", int'(tick), 0);
        enable  = 1'b1;
        heating = 1'b0;
        cooling = 1'b1;
        step(4);
        check("t2_c1", int'(temperature), 1);
        check("t2_c1_min", int'(at_min), 0);
        step(4);
        check("t2_c2", int'(temperature), 0);
        check("t2_c2_min", int'(at_min), 1);
        step(4);
        check("t2_c3", int'(temperature), 0);
        check("t2_c3_tick", int'(tick), 1);
        step(4);
        check("t2_c4", int'(temperature), 0);
        check("t2_c4_min", int'(at_min), 1);

        // 3: ambient drift down from 25, then up from 10
        cooling = 1'b0;
        do_load(5'd25);
        step(15);
        check("t3_hold25", int'(temperature), 25);
        step(1);
        check("t3_d24", int'(temperature), 24);
        for (int i = 1; i <= 6; i++) begin
            step(16);
            check("t3_down", int'(temperature), 24 - i);
        end
        step(32);
        check("t3_hold18", int'(temperature), 18);
        do_load(5'd10);
        for (int i = 1; i <= 8; i++) begin
            step(16);
            check("t3_up", int'(temperature), 10 + i);
        end
        step(32);
        check("t3_hold18b", int'(temperature), 18);

        // 4: simultaneous commands -> hold + sticky fault
        do_load(5'd20);
        heating = 1'b1;
        cooling = 1'b1;
        step(4);
        check("t4_temp",  int'(temperature), 20);
        check("t4_fault", int'(fault), 1);
        heating = 1'b0;
        cooling = 1'b0;
        step(4);
        check("t4_sticky", int'(fault), 1);
        check("t4_idle_temp", int'(temperature), 20);
        do_load(5'd5);
        check("t4_load_keeps_fault", int'(fault), 1);
        rst_n = 1'b0;
        #1;
        check("t4_rst_fault", int'(fault), 0);
        check("t4_rst_temp",  int'(temperature), 18);
        #1;
        rst_n = 1'b1;

        // 5: load mid-count restarts the divider; enable=0 freezes state
        heating = 1'b1;
        step(2);
        do_load(5'd7);
        check("t5_load_temp", int'(temperature), 7);
        step(3);
        check("t5_no_tick_yet", int'(tick), 0);
        check("t5_pre_temp", int'(temperature), 7);
        step(1);
        check("t5_tick", int'(tick), 1);
        check("t5_temp8", int'(temperature), 8);
        step(2);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("t5_frozen_tick", int'(tick), 0);
            check("t5_frozen_temp", int'(temperature), 8);
        end
        enable = 1'b1;
        step(1);
        check("t5_resume_notick", int'(tick), 0);
        step(1);
        check("t5_resume_tick", int'(tick), 1);
        check("t5_resume_temp", int'(temperature), 9);

        // 6: asynchronous reset between edges while tick and fault are high
        cooling = 1'b1;
        step(4);
        check("t6_pre_tick",  int'(tick), 1);
        check("t6_pre_fault", int'(fault), 1);
        check("t6_pre_temp",  int'(temperature), 9);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_temp",  int'(temperature), 18);
        check("t6_async_tick",  int'(tick), 0);
        check("t6_async_fault", int'(fault), 0);
        #1;
        rst_n   = 1'b1;
        heating = 1'b0;
        cooling = 1'b0;
        step(2);

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
